// File: rtl/fp_prf_v2.sv
// FP physical register file with per-register ready scoreboard and busy count.
// Optional same-cycle write-to-read forwarding is enabled by defining FP_PRF_BYPASS_EN.

module fp_prf_v2_rd #(
  parameter int AW     = 7,
  parameter int XLEN   = 64,
  parameter int NUM_WR = 4,
  parameter bit BYPASS = 1'b0
) (
  input  logic [AW-1:0]                addr,
  input  logic [XLEN-1:0]              mem_data,
  input  logic                         mem_ready,
  input  logic [NUM_WR-1:0]            wr_valid,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data,
  output logic [XLEN-1:0]              data,
  output logic                         ready
);
  // Ascending scan so the highest-index matching write port is forwarded.
  always_comb begin
    data  = mem_data;
    ready = mem_ready;
    for (int k = 0; k < NUM_WR; k++) begin
      if (BYPASS && wr_valid[k] && wr_addr[k] == addr && addr != '0) begin
        data  = wr_data[k];
        ready = 1'b1;
      end
    end
  end
endmodule

module fp_prf_v2 #(
  parameter int REG_SIZE  = 128,
  parameter int AW        = $clog2(REG_SIZE),
  parameter int XLEN      = 64,
  parameter int NUM_RD    = 6,
  parameter int NUM_WR    = 4,
  parameter int NUM_ALLOC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_RD*AW-1:0]      rd_addr_i,
  output logic [NUM_RD*XLEN-1:0]    rd_data_o,
  output logic [NUM_RD-1:0]         rd_ready_o,
  input  logic [NUM_WR-1:0]         wr_valid_i,
  input  logic [NUM_WR*AW-1:0]      wr_addr_i,
  input  logic [NUM_WR*XLEN-1:0]    wr_data_i,
  input  logic [NUM_ALLOC-1:0]      alloc_valid_i,
  input  logic [NUM_ALLOC*AW-1:0]   alloc_addr_i,
  input  logic                      flush_i,
  output logic [AW:0]               busy_cnt_o
);
`ifdef FP_PRF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [NUM_RD-1:0][AW-1:0]      rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]    rd_data;
  logic [NUM_WR-1:0][AW-1:0]      wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0]    wr_data;
  logic [NUM_ALLOC-1:0][AW-1:0]   alloc_addr;

  assign rd_addr    = rd_addr_i;
  assign wr_addr    = wr_addr_i;
  assign wr_data    = wr_data_i;
  assign alloc_addr = alloc_addr_i;
  assign rd_data_o  = rd_data;

  logic [XLEN-1:0]     mem [REG_SIZE];
  logic [REG_SIZE-1:0] ready_q, ready_d;
  logic [AW:0]         busy_q, busy_d;

  // Priority: writes set, allocs clear over writes, flush sets everything last.
  always_comb begin
    ready_d = ready_q;
    for (int k = 0; k < NUM_WR; k++)
      if (wr_valid_i[k]) ready_d[wr_addr[k]] = 1'b1;
    for (int j = 0; j < NUM_ALLOC; j++)
      if (alloc_valid_i[j] && !flush_i) ready_d[alloc_addr[j]] = 1'b0;
    if (flush_i) ready_d = '1;
    ready_d[0] = 1'b1;
  end

  // Counting the next-state array keeps the count aligned with the ready bits.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < REG_SIZE; i++)
      busy_d = busy_d + (AW+1)'(~ready_d[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_SIZE; i++) mem[i] <= '0;
      ready_q <= '1;
      busy_q  <= '0;
    end else begin
      // Later NBAs win, so the highest-index port takes a shared address.
      for (int k = 0; k < NUM_WR; k++)
        if (wr_valid_i[k] && wr_addr[k] != '0) mem[wr_addr[k]] <= wr_data[k];
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_cnt_o = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    fp_prf_v2_rd #(
      .AW(AW), .XLEN(XLEN), .NUM_WR(NUM_WR), .BYPASS(BYPASS)
    ) u_rd (
      .addr     (rd_addr[k]),
      .mem_data (mem[rd_addr[k]]),
      .mem_ready(ready_q[rd_addr[k]]),
      .wr_valid (wr_valid_i),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .data     (rd_data[k]),
      .ready    (rd_ready_o[k])
    );
  end
endmodule

// File: tb/tb_fp_prf_v2.sv
// Bench for fp_prf_v2: directed scenarios plus randomized traffic against a register-level model.
module tb_fp_prf_v2;
  localparam int REG_SIZE = 128, AW = 7, XLEN = 64, NUM_RD = 6, NUM_WR = 4, NUM_ALLOC = 2;
`ifdef FP_PRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NUM_RD-1:0][AW-1:0]      rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]    rd_data;
  logic [NUM_RD-1:0]              rd_ready;
  logic [NUM_WR-1:0]              wr_valid;
  logic [NUM_WR-1:0][AW-1:0]      wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0]    wr_data;
  logic [NUM_ALLOC-1:0]           alloc_valid;
  logic [NUM_ALLOC-1:0][AW-1:0]   alloc_addr;
  logic                           flush;
  logic [AW:0]                    busy;

  int tests = 0;
  int fails = 0;

  logic [XLEN-1:0] m_data [REG_SIZE];
  bit              m_ready [REG_SIZE];

  always #5 clk = ~clk;

  fp_prf_v2 dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_ready_o(rd_ready),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_valid_i(alloc_valid), .alloc_addr_i(alloc_addr),
    .flush_i(flush), .busy_cnt_o(busy)
  );

  function automatic logic [XLEN-1:0] exp_data(input int a);
    logic [XLEN-1:0] d = m_data[a];
    if (BYP && a != 0)
      for (int k = 0; k < NUM_WR; k++)
        if (wr_valid[k] && int'(wr_addr[k]) == a) d = wr_data[k];
    return d;
  endfunction

  function automatic bit exp_ready(input int a);
    bit r = m_ready[a];
    if (BYP && a != 0)
      for (int k = 0; k < NUM_WR; k++)
        if (wr_valid[k] && int'(wr_addr[k]) == a) r = 1'b1;
    return r;
  endfunction

  function automatic int exp_busy();
    int n = 0;
    for (int i = 0; i < REG_SIZE; i++) if (!m_ready[i]) n++;
    return n;
  endfunction

  // Register-file behaviour at a clock edge, applied to the inputs that were held across it.
  task automatic model_edge();
    if (!rst_n) begin
      for (int i = 0; i < REG_SIZE; i++) begin m_data[i] = '0; m_ready[i] = 1'b1; end
    end else begin
      for (int k = 0; k < NUM_WR; k++)
        if (wr_valid[k] && wr_addr[k] != 0) begin
          m_data[wr_addr[k]]  = wr_data[k];
          m_ready[wr_addr[k]] = 1'b1;
        end
      if (!flush)
        for (int j = 0; j < NUM_ALLOC; j++)
          if (alloc_valid[j] && alloc_addr[j] != 0) m_ready[alloc_addr[j]] = 1'b0;
      if (flush)
        for (int i = 0; i < REG_SIZE; i++) m_ready[i] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_valid = '0; alloc_valid = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_valid = '1; alloc_valid = '1; flush = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin wr_addr[k] = AW'(k + 5); wr_data[k] = {$urandom, $urandom}; end
    for (int j = 0; j < NUM_ALLOC; j++) alloc_addr[j] = AW'(j + 40);
    rd_addr = '0;
    tick(); tick();
    idle(); rst_n = 1'b1;
    rd_addr[0] = 7'd5; rd_addr[1] = 7'd40;
    #1;
    tests++; if (rd_data[0] !== 64'h0) begin fails++; $display("FAIL reset_data got=%h exp=%h", rd_data[0], 64'h0); end
    tests++; if (rd_ready[0] !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", rd_ready[0]); end
    tests++; if (rd_ready[1] !== 1'b1) begin fails++; $display("FAIL reset_alloc_ignored got=%b exp=1", rd_ready[1]); end
    tests++; if (busy !== 8'd0) begin fails++; $display("FAIL reset_busy got=%0d exp=0", busy); end
  endtask

  task automatic test_alloc_write();
    idle(); alloc_valid[0] = 1'b1; alloc_addr[0] = 7'd7;
    tick(); idle();
    rd_addr[0] = 7'd7; #1;
    tests++; if (rd_ready[0] !== 1'b0) begin fails++; $display("FAIL alloc_ready got=%b exp=0", rd_ready[0]); end
    tests++; if (busy !== 8'd1) begin fails++; $display("FAIL alloc_busy got=%0d exp=1", busy); end
    wr_valid[0] = 1'b1; wr_addr[0] = 7'd7; wr_data[0] = 64'hDEAD_BEEF_0000_0001;
    tick(); idle(); #1;
    tests++; if (rd_ready[0] !== 1'b1) begin fails++; $display("FAIL write_ready got=%b exp=1", rd_ready[0]); end
    tests++; if (rd_data[0] !== 64'hDEAD_BEEF_0000_0001) begin fails++; $display("FAIL write_data got=%h exp=%h", rd_data[0], 64'hDEAD_BEEF_0000_0001); end
    tests++; if (busy !== 8'd0) begin fails++; $display("FAIL write_busy got=%0d exp=0", busy); end
  endtask

  task automatic test_write_conflict();
    idle();
    wr_valid = 4'b1011;
    wr_addr[0] = 7'd9; wr_data[0] = 64'd1;
    wr_addr[1] = 7'd0; wr_data[1] = 64'hFFFF;
    wr_addr[3] = 7'd9; wr_data[3] = 64'd3;
    tick(); idle();
    rd_addr[0] = 7'd9; rd_addr[1] = 7'd0; #1;
    tests++; if (rd_data[0] !== 64'd3) begin fails++; $display("FAIL conflict_data got=%h exp=%h", rd_data[0], 64'd3); end
    tests++; if (rd_data[1] !== 64'd0) begin fails++; $display("FAIL p0_data got=%h exp=0", rd_data[1]); end
    tests++; if (rd_ready[1] !== 1'b1) begin fails++; $display("FAIL p0_ready got=%b exp=1", rd_ready[1]); end
  endtask

  task automatic test_alloc_write_same();
    idle();
    alloc_valid[1] = 1'b1; alloc_addr[1] = 7'd12;
    wr_valid[2] = 1'b1; wr_addr[2] = 7'd12; wr_data[2] = 64'd5;
    tick(); idle();
    rd_addr[0] = 7'd12; #1;
    tests++; if (rd_ready[0] !== 1'b0) begin fails++; $display("FAIL aw_ready got=%b exp=0", rd_ready[0]); end
    tests++; if (rd_data[0] !== 64'd5) begin fails++; $display("FAIL aw_data got=%h exp=5", rd_data[0]); end
    tests++; if (busy !== 8'd1) begin fails++; $display("FAIL aw_busy got=%0d exp=1", busy); end
  endtask

  task automatic test_flush();
    idle();
    alloc_valid = 2'b11; alloc_addr[0] = 7'd20; alloc_addr[1] = 7'd21;
    tick(); idle(); #1;
    tests++; if (busy !== 8'd3) begin fails++; $display("FAIL preflush_busy got=%0d exp=3", busy); end
    flush = 1'b1; alloc_valid[0] = 1'b1; alloc_addr[0] = 7'd22;
    tick(); idle();
    rd_addr[0] = 7'd20; rd_addr[1] = 7'd21; rd_addr[2] = 7'd22; rd_addr[3] = 7'd12; #1;
    for (int p = 0; p < 4; p++) begin
      tests++; if (rd_ready[p] !== 1'b1) begin fails++; $display("FAIL flush_ready port%0d got=%b exp=1", p, rd_ready[p]); end
    end
    tests++; if (busy !== 8'd0) begin fails++; $display("FAIL flush_busy got=%0d exp=0", busy); end
  endtask

  task automatic test_bypass();
    idle(); wr_valid[0] = 1'b1; wr_addr[0] = 7'd30; wr_data[0] = 64'h5555;
    tick(); idle();
    wr_valid[1] = 1'b1; wr_addr[1] = 7'd30; wr_data[1] = 64'h1234;
    rd_addr[0] = 7'd30; #1;
    tests++;
    if (rd_data[0] !== (BYP ? 64'h1234 : 64'h5555)) begin
      fails++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd_data[0], BYP ? 64'h1234 : 64'h5555);
    end
    tick(); idle(); #1;
    tests++; if (rd_data[0] !== 64'h1234) begin fails++; $display("FAIL bypass_next_cycle got=%h exp=%h", rd_data[0], 64'h1234); end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, REG_SIZE-1)) : AW'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        wr_valid[k] = ($urandom_range(0, 2) == 0);
        wr_addr[k]  = rnd_addr();
        wr_data[k]  = {$urandom, $urandom};
      end
      for (int j = 0; j < NUM_ALLOC; j++) begin
        alloc_valid[j] = ($urandom_range(0, 1) == 1);
        alloc_addr[j]  = rnd_addr();
      end
      flush = ($urandom_range(0, 24) == 0);
      for (int p = 0; p < NUM_RD; p++) rd_addr[p] = rnd_addr();
      #1;
      for (int p = 0; p < NUM_RD; p++) begin
        tests++;
        if (rd_data[p] !== exp_data(int'(rd_addr[p]))) begin
          fails++; $display("FAIL rand_data cyc%0d port%0d addr%0d got=%h exp=%h", c, p, rd_addr[p], rd_data[p], exp_data(int'(rd_addr[p])));
        end
        tests++;
        if (rd_ready[p] !== exp_ready(int'(rd_addr[p]))) begin
          fails++; $display("FAIL rand_ready cyc%0d port%0d addr%0d got=%b exp=%b", c, p, rd_addr[p], rd_ready[p], exp_ready(int'(rd_addr[p])));
        end
      end
      tests++;
      if (int'(busy) != exp_busy()) begin
        fails++; $display("FAIL rand_busy cyc%0d got=%0d exp=%0d", c, busy, exp_busy());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle(); rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
    test_reset();
    test_alloc_write();
    test_write_conflict();
    test_alloc_write_same();
    test_flush();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
